// File: rtl/vend_txn_controller_pkg.sv
// Shared types and widths for the vending transaction sequencer.
package vend_txn_controller_pkg;

   localparam int unsigned ID_W   = 3;
   localparam int unsigned QTY_W  = 4;
   localparam int unsigned COIN_W = 8;
   localparam int unsigned ERR_W  = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CHECK    = 3'd1,
      ST_COLLECT  = 3'd2,
      ST_DISPENSE = 3'd3,
      ST_CHANGE   = 3'd4,
      ST_REFUND   = 3'd5
   } state_t;

   typedef enum logic [ERR_W-1:0] {
      ERR_NONE     = 2'd0,
      ERR_BAD_QTY  = 2'd1,
      ERR_NO_STOCK = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_t;

   // Latched product selection driven into the datapath
   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [QTY_W-1:0] qty;
   } sel_t;

endpackage

// File: rtl/vend_txn_controller_if.sv
// Front-end, datapath and payout signals of the transaction sequencer.
interface vend_txn_controller_if #(
   parameter int unsigned PAY_W = 16
) ();
   import vend_txn_controller_pkg::*;

   logic                 sel_valid;
   logic [ID_W-1:0]      sel_id;
   logic [QTY_W-1:0]     sel_qty;
   logic                 coin_valid;
   logic [COIN_W-1:0]    coin_value;
   logic                 coin_ready;
   logic                 cancel;
   logic [ID_W-1:0]      dp_id;
   logic [QTY_W-1:0]     dp_qty;
   logic [PAY_W-1:0]     dp_cost;
   logic [QTY_W-1:0]     dp_stock;
   logic                 vend_valid;
   logic                 vend_ready;
   logic                 inv_dec;
   logic                 chg_valid;
   logic [PAY_W-1:0]     chg_amount;
   logic                 chg_ready;
   logic [PAY_W-1:0]     paid_total;
   logic [ERR_W-1:0]     err;
   logic                 busy;

   // Environment side: user front-end, datapath, mechanism, payout
   modport master (
      output sel_valid, sel_id, sel_qty, coin_valid, coin_value, cancel,
             dp_cost, dp_stock, vend_ready, chg_ready,
      input  coin_ready, dp_id, dp_qty, vend_valid, inv_dec, chg_valid,
             chg_amount, paid_total, err, busy
   );

   // Controller side
   modport slave (
      input  sel_valid, sel_id, sel_qty, coin_valid, coin_value, cancel,
             dp_cost, dp_stock, vend_ready, chg_ready,
      output coin_ready, dp_id, dp_qty, vend_valid, inv_dec, chg_valid,
             chg_amount, paid_total, err, busy
   );

endinterface

// File: rtl/vend_txn_controller_coin_acc.sv
// Saturating coin accumulator with an idle-cycle timeout counter.
module vend_txn_controller_coin_acc
   import vend_txn_controller_pkg::*;
#(
   parameter int unsigned PAY_W       = 16,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              run,
   input  logic              add,
   input  logic [COIN_W-1:0] value,
   output logic [PAY_W-1:0]  paid,
   output logic [PAY_W-1:0]  paid_next_c,
   output logic              expire_c
);

   localparam int unsigned     TMR_W   = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(TIMEOUT_CYC);

   logic [PAY_W-1:0] paid_q, paid_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [PAY_W:0]   sum;

   // Next total (saturating) and idle timer; a coin restarts the timer
   always_comb begin
      sum         = (PAY_W+1)'(paid_q) + (PAY_W+1)'(value);
      paid_next_c = paid_q;
      if (add) begin
         paid_next_c = sum[PAY_W] ? '1 : sum[PAY_W-1:0];
      end
      paid_d  = clear ? '0 : paid_next_c;
      timer_d = timer_q;
      if (clear) begin
         timer_d = '0;
      end else if (run) begin
         if (add) begin
            timer_d = '0;
         end else if (timer_q != TMR_LIM) begin
            timer_d = timer_q + TMR_W'(1);
         end
      end
      expire_c = (TIMEOUT_CYC != 0) && run && (timer_q == TMR_LIM);
   end

   // Accumulator and timer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         paid_q  <= '0;
         timer_q <= '0;
      end else begin
         paid_q  <= paid_d;
         timer_q <= timer_d;
      end
   end

   assign paid = paid_q;

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: select, stock check, collect, dispense, change/refund.
module vend_txn_controller
   import vend_txn_controller_pkg::*;
#(
   parameter int unsigned PAY_W       = 16,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input logic                  clk,
   input logic                  reset,
   vend_txn_controller_if.slave bus
);

   state_t           state_q, state_d;
   sel_t             sel_q, sel_d;
   logic [PAY_W-1:0] cost_q, cost_d;
   logic [PAY_W-1:0] chg_amount_q, chg_amount_d;
   logic             chg_valid_q, chg_valid_d;
   logic             coin_ready_q, coin_ready_d;
   logic             vend_valid_q, vend_valid_d;
   logic             inv_dec_q, inv_dec_d;
   logic             busy_q, busy_d;
   err_t             err_q, err_d;

   logic             acc_clear_c;
   logic             acc_run_c;
   logic             acc_add_c;
   logic [PAY_W-1:0] paid;
   logic [PAY_W-1:0] paid_next_c;
   logic             expire_c;

   assign acc_run_c = (state_q == ST_COLLECT);
   assign acc_add_c = acc_run_c && bus.coin_valid;

   vend_txn_controller_coin_acc #(
      .PAY_W       (PAY_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_coin_acc (
      .clk         (clk),
      .reset       (reset),
      .clear       (acc_clear_c),
      .run         (acc_run_c),
      .add         (acc_add_c),
      .value       (bus.coin_value),
      .paid        (paid),
      .paid_next_c (paid_next_c),
      .expire_c    (expire_c)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cost_d       = cost_q;
      chg_amount_d = chg_amount_q;
      chg_valid_d  = chg_valid_q;
      inv_dec_d    = 1'b0;
      err_d        = ERR_NONE;
      acc_clear_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.sel_valid) begin
               if (bus.sel_qty == '0) begin
                  err_d = ERR_BAD_QTY;
               end else begin
                  sel_d   = '{id: bus.sel_id, qty: bus.sel_qty};
                  state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (bus.dp_stock < sel_q.qty) begin
               err_d   = ERR_NO_STOCK;
               state_d = ST_IDLE;
            end else begin
               cost_d      = bus.dp_cost;
               acc_clear_c = 1'b1;
               state_d     = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            // A funded transaction commits to dispense even if cancel arrives now
            if (paid >= cost_q) begin
               state_d = ST_DISPENSE;
            end else if (bus.cancel || expire_c) begin
               chg_amount_d = paid_next_c;
               chg_valid_d  = (paid_next_c != '0);
               state_d      = ST_REFUND;
               if (!bus.cancel) begin
                  err_d = ERR_TIMEOUT;
               end
            end
         end
         ST_DISPENSE: begin
            if (bus.vend_ready) begin
               inv_dec_d    = 1'b1;
               chg_amount_d = paid - cost_q;
               chg_valid_d  = (paid != cost_q);
               state_d      = ST_CHANGE;
            end
         end
         ST_CHANGE, ST_REFUND: begin
            if (!chg_valid_q || bus.chg_ready) begin
               chg_valid_d  = 1'b0;
               chg_amount_d = '0;
               acc_clear_c  = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      coin_ready_d = (state_d == ST_COLLECT);
      vend_valid_d = (state_d == ST_DISPENSE);
      busy_d       = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         sel_q        <= '0;
         cost_q       <= '0;
         chg_amount_q <= '0;
         chg_valid_q  <= 1'b0;
         coin_ready_q <= 1'b0;
         vend_valid_q <= 1'b0;
         inv_dec_q    <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= ERR_NONE;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cost_q       <= cost_d;
         chg_amount_q <= chg_amount_d;
         chg_valid_q  <= chg_valid_d;
         coin_ready_q <= coin_ready_d;
         vend_valid_q <= vend_valid_d;
         inv_dec_q    <= inv_dec_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   assign bus.coin_ready = coin_ready_q;
   assign bus.dp_id      = sel_q.id;
   assign bus.dp_qty     = sel_q.qty;
   assign bus.vend_valid = vend_valid_q;
   assign bus.inv_dec    = inv_dec_q;
   assign bus.chg_valid  = chg_valid_q;
   assign bus.chg_amount = chg_amount_q;
   assign bus.paid_total = paid;
   assign bus.err        = err_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed self-checking bench for the vending transaction sequencer.
module tb_vend_txn_controller;

   localparam int unsigned PAY_W = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   vend_txn_controller_if #(.PAY_W(PAY_W)) bus ();

   vend_txn_controller #(
      .PAY_W       (PAY_W),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs set afterwards are sampled at the next edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a selection for one cycle, then spend the CHECK cycle
   task automatic start_txn(input logic [2:0] id, input logic [3:0] qty);
      bus.sel_valid = 1'b1;
      bus.sel_id    = id;
      bus.sel_qty   = qty;
      tick();
      bus.sel_valid = 1'b0;
      tick();
   endtask

   // Insert one coin for one cycle
   task automatic coin(input logic [7:0] v);
      bus.coin_valid = 1'b1;
      bus.coin_value = v;
      tick();
      bus.coin_valid = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
      total++;
      if ({bus.coin_ready, bus.vend_valid, bus.inv_dec, bus.chg_valid} !== 4'b0000) begin
         bad++; $display("FAIL rst_flags: got %b want 0000", {bus.coin_ready, bus.vend_valid, bus.inv_dec, bus.chg_valid});
      end
      total++;
      if ({bus.paid_total, bus.chg_amount, bus.dp_id, bus.dp_qty, bus.err} !== 41'd0) begin
         bad++; $display("FAIL rst_data: paid=%0d chg=%0d id=%0d qty=%0d err=%0d want all 0",
                         bus.paid_total, bus.chg_amount, bus.dp_id, bus.dp_qty, bus.err);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_happy();
      bus.dp_stock = 4'd15;
      bus.dp_cost  = 16'd100;
      bus.sel_valid = 1'b1; bus.sel_id = 3'd1; bus.sel_qty = 4'd5;
      tick();
      bus.sel_valid = 1'b0;
      total++;
      if (bus.dp_id !== 3'd1 || bus.dp_qty !== 4'd5 || bus.busy !== 1'b1) begin
         bad++; $display("FAIL happy_latch: id=%0d qty=%0d busy=%0b want 1 5 1", bus.dp_id, bus.dp_qty, bus.busy);
      end
      tick();
      total++;
      if (bus.coin_ready !== 1'b1 || bus.paid_total !== 16'd0) begin
         bad++; $display("FAIL happy_collect: ready=%0b paid=%0d want 1 0", bus.coin_ready, bus.paid_total);
      end
      coin(8'd50);
      total++;
      if (bus.paid_total !== 16'd50) begin bad++; $display("FAIL happy_paid1: got %0d want 50", bus.paid_total); end
      coin(8'd50);
      total++;
      if (bus.paid_total !== 16'd100 || bus.coin_ready !== 1'b1) begin
         bad++; $display("FAIL happy_paid2: paid=%0d ready=%0b want 100 1", bus.paid_total, bus.coin_ready);
      end
      tick();
      total++;
      if (bus.vend_valid !== 1'b1 || bus.coin_ready !== 1'b0) begin
         bad++; $display("FAIL happy_vend: vend=%0b ready=%0b want 1 0", bus.vend_valid, bus.coin_ready);
      end
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      total++;
      if (bus.vend_valid !== 1'b1 || bus.dp_id !== 3'd1 || bus.dp_qty !== 4'd5 || bus.inv_dec !== 1'b0) begin
         bad++; $display("FAIL happy_hold: vend=%0b id=%0d qty=%0d dec=%0b want 1 1 5 0",
                         bus.vend_valid, bus.dp_id, bus.dp_qty, bus.inv_dec);
      end
      bus.vend_ready = 1'b1;
      tick();
      bus.vend_ready = 1'b0;
      total++;
      if (bus.inv_dec !== 1'b1 || bus.vend_valid !== 1'b0 || bus.chg_valid !== 1'b0) begin
         bad++; $display("FAIL happy_dec: dec=%0b vend=%0b chg=%0b want 1 0 0", bus.inv_dec, bus.vend_valid, bus.chg_valid);
      end
      tick();
      total++;
      if (bus.inv_dec !== 1'b0 || bus.busy !== 1'b0 || bus.chg_valid !== 1'b0 || bus.paid_total !== 16'd0) begin
         bad++; $display("FAIL happy_idle: dec=%0b busy=%0b chg=%0b paid=%0d want 0 0 0 0",
                         bus.inv_dec, bus.busy, bus.chg_valid, bus.paid_total);
      end
   endtask

   task automatic test_overpay();
      bus.dp_stock = 4'd15;
      bus.dp_cost  = 16'd90;
      start_txn(3'd3, 4'd2);
      coin(8'd50);
      coin(8'd50);
      tick();
      total++;
      if (bus.vend_valid !== 1'b1) begin bad++; $display("FAIL over_vend: got %0b want 1", bus.vend_valid); end
      bus.vend_ready = 1'b1;
      tick();
      bus.vend_ready = 1'b0;
      total++;
      if (bus.chg_valid !== 1'b1 || bus.chg_amount !== 16'd10 || bus.inv_dec !== 1'b1) begin
         bad++; $display("FAIL over_chg: valid=%0b amt=%0d dec=%0b want 1 10 1", bus.chg_valid, bus.chg_amount, bus.inv_dec);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (bus.chg_valid !== 1'b1 || bus.chg_amount !== 16'd10 || bus.inv_dec !== 1'b0) begin
            bad++; $display("FAIL over_hold%0d: valid=%0b amt=%0d dec=%0b want 1 10 0",
                            i, bus.chg_valid, bus.chg_amount, bus.inv_dec);
         end
      end
      bus.chg_ready = 1'b1;
      tick();
      bus.chg_ready = 1'b0;
      total++;
      if (bus.chg_valid !== 1'b0 || bus.busy !== 1'b0 || bus.paid_total !== 16'd0) begin
         bad++; $display("FAIL over_idle: valid=%0b busy=%0b paid=%0d want 0 0 0", bus.chg_valid, bus.busy, bus.paid_total);
      end
   endtask

   task automatic test_stock();
      bus.dp_stock = 4'd5;
      bus.dp_cost  = 16'd30;
      bus.sel_valid = 1'b1; bus.sel_id = 3'd2; bus.sel_qty = 4'd10;
      tick();
      bus.sel_valid = 1'b0;
      tick();
      total++;
      if (bus.err !== 2'd2 || bus.busy !== 1'b0 || bus.coin_ready !== 1'b0) begin
         bad++; $display("FAIL stock_err: err=%0d busy=%0b ready=%0b want 2 0 0", bus.err, bus.busy, bus.coin_ready);
      end
      tick();
      total++;
      if (bus.err !== 2'd0 || bus.coin_ready !== 1'b0) begin
         bad++; $display("FAIL stock_pulse: err=%0d ready=%0b want 0 0", bus.err, bus.coin_ready);
      end
      bus.sel_valid = 1'b1; bus.sel_id = 3'd2; bus.sel_qty = 4'd0;
      tick();
      bus.sel_valid = 1'b0;
      total++;
      if (bus.err !== 2'd1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL badqty_err: err=%0d busy=%0b want 1 0", bus.err, bus.busy);
      end
      tick();
      total++;
      if (bus.err !== 2'd0) begin bad++; $display("FAIL badqty_pulse: err=%0d want 0", bus.err); end
   endtask

   task automatic test_cancel();
      bus.dp_stock = 4'd15;
      bus.dp_cost  = 16'd200;
      start_txn(3'd4, 4'd1);
      coin(8'd100);
      bus.coin_valid = 1'b1; bus.coin_value = 8'd20; bus.cancel = 1'b1;
      tick();
      bus.coin_valid = 1'b0; bus.cancel = 1'b0;
      total++;
      if (bus.chg_valid !== 1'b1 || bus.chg_amount !== 16'd120 || bus.paid_total !== 16'd120) begin
         bad++; $display("FAIL cancel_refund: valid=%0b amt=%0d paid=%0d want 1 120 120",
                         bus.chg_valid, bus.chg_amount, bus.paid_total);
      end
      total++;
      if (bus.coin_ready !== 1'b0 || bus.inv_dec !== 1'b0 || bus.vend_valid !== 1'b0 || bus.err !== 2'd0) begin
         bad++; $display("FAIL cancel_flags: ready=%0b dec=%0b vend=%0b err=%0d want 0 0 0 0",
                         bus.coin_ready, bus.inv_dec, bus.vend_valid, bus.err);
      end
      bus.chg_ready = 1'b1;
      tick();
      bus.chg_ready = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.inv_dec !== 1'b0 || bus.chg_valid !== 1'b0) begin
         bad++; $display("FAIL cancel_idle: busy=%0b dec=%0b valid=%0b want 0 0 0", bus.busy, bus.inv_dec, bus.chg_valid);
      end
   endtask

   task automatic test_timeout();
      bus.dp_stock = 4'd15;
      bus.dp_cost  = 16'd50;
      start_txn(3'd5, 4'd1);
      coin(8'd10);
      for (int i = 0; i < 8; i++) begin
         tick();
      end
      total++;
      if (bus.coin_ready !== 1'b1 || bus.err !== 2'd0) begin
         bad++; $display("FAIL tmo_early: ready=%0b err=%0d want 1 0", bus.coin_ready, bus.err);
      end
      tick();
      total++;
      if (bus.err !== 2'd3 || bus.chg_valid !== 1'b1 || bus.chg_amount !== 16'd10 || bus.coin_ready !== 1'b0) begin
         bad++; $display("FAIL tmo_refund: err=%0d valid=%0b amt=%0d ready=%0b want 3 1 10 0",
                         bus.err, bus.chg_valid, bus.chg_amount, bus.coin_ready);
      end
      bus.chg_ready = 1'b1;
      tick();
      bus.chg_ready = 1'b0;
      total++;
      if (bus.err !== 2'd0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL tmo_idle: err=%0d busy=%0b want 0 0", bus.err, bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      bus.dp_stock = 4'd15;
      bus.dp_cost  = 16'd100;
      start_txn(3'd6, 4'd3);
      coin(8'd60);
      total++;
      if (bus.paid_total !== 16'd60) begin bad++; $display("FAIL rmid_paid: got %0d want 60", bus.paid_total); end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({bus.busy, bus.coin_ready, bus.vend_valid, bus.chg_valid} !== 4'b0000 ||
          bus.paid_total !== 16'd0 || bus.dp_id !== 3'd0 || bus.dp_qty !== 4'd0) begin
         bad++; $display("FAIL rmid_async: busy=%0b ready=%0b paid=%0d id=%0d qty=%0d want 0 0 0 0 0",
                         bus.busy, bus.coin_ready, bus.paid_total, bus.dp_id, bus.dp_qty);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      bus.sel_valid = 1'b1; bus.sel_id = 3'd7; bus.sel_qty = 4'd1;
      tick();
      bus.sel_valid = 1'b0;
      total++;
      if (bus.busy !== 1'b1 || bus.dp_id !== 3'd7) begin
         bad++; $display("FAIL rmid_sel: busy=%0b id=%0d want 1 7", bus.busy, bus.dp_id);
      end
      tick();
      total++;
      if (bus.coin_ready !== 1'b1 || bus.paid_total !== 16'd0) begin
         bad++; $display("FAIL rmid_collect: ready=%0b paid=%0d want 1 0", bus.coin_ready, bus.paid_total);
      end
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      total++;
      if (bus.chg_valid !== 1'b0 || bus.busy !== 1'b1) begin
         bad++; $display("FAIL rmid_zero_refund: valid=%0b busy=%0b want 0 1", bus.chg_valid, bus.busy);
      end
      tick();
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_idle: busy=%0b want 0", bus.busy); end
   endtask

   initial begin
      bus.sel_valid  = 1'b0;
      bus.sel_id     = '0;
      bus.sel_qty    = '0;
      bus.coin_valid = 1'b0;
      bus.coin_value = '0;
      bus.cancel     = 1'b0;
      bus.dp_cost    = '0;
      bus.dp_stock   = '0;
      bus.vend_ready = 1'b0;
      bus.chg_ready  = 1'b0;
      test_reset();
      test_happy();
      test_overpay();
      test_stock();
      test_cancel();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guard against a stuck run
   initial begin
      #200000;
      $display("FAIL watchdog: run did not end, bad=%0d", bad);
      $fatal(1);
   end

endmodule
